rs_alu: RTL and testbench

//  8-entry ALU reservation station directly downstream of srcopr_sel_unit. It accepts up to 2

---
 rtl/rs_alu.sv | 179 +++++++++++++++++
 tb/tb_rs_alu.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rs_alu.sv
// rtl/rs_alu.sv - 8-entry ALU reservation station with dual dispatch, dual wakeup, single issue
module rs_alu #(
    parameter int RS_ENT = 8,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6,
    parameter int PLD_W  = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_kill,
    input  logic                      i_dp1_we,
    input  logic                      i_dp1_src1_vld,
    input  logic [DATA_W-1:0]         i_dp1_src1,
    input  logic                      i_dp1_src2_vld,
    input  logic [DATA_W-1:0]         i_dp1_src2,
    input  logic [TAG_W-1:0]          i_dp1_dst_tag,
    input  logic [PLD_W-1:0]          i_dp1_pld,
    input  logic                      i_dp2_we,
    input  logic                      i_dp2_src1_vld,
    input  logic [DATA_W-1:0]         i_dp2_src1,
    input  logic                      i_dp2_src2_vld,
    input  logic [DATA_W-1:0]         i_dp2_src2,
    input  logic [TAG_W-1:0]          i_dp2_dst_tag,
    input  logic [PLD_W-1:0]          i_dp2_pld,
    input  logic                      i_wb1_vld,
    input  logic [TAG_W-1:0]          i_wb1_tag,
    input  logic [DATA_W-1:0]         i_wb1_data,
    input  logic                      i_wb2_vld,
    input  logic [TAG_W-1:0]          i_wb2_tag,
    input  logic [DATA_W-1:0]         i_wb2_data,
    output logic [$clog2(RS_ENT):0]   o_free_cnt,
    output logic                      o_issue_vld,
    input  logic                      i_issue_rdy,
    output logic [DATA_W-1:0]         o_issue_src1,
    output logic [DATA_W-1:0]         o_issue_src2,
    output logic [TAG_W-1:0]          o_issue_dst_tag,
    output logic [PLD_W-1:0]          o_issue_pld
);
    localparam int IDX_W = $clog2(RS_ENT);
    localparam int CNT_W = IDX_W + 1;

    logic [RS_ENT-1:0] busy_q, busy_d;
    logic [RS_ENT-1:0] s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
    logic [DATA_W-1:0] s1_q [RS_ENT];
    logic [DATA_W-1:0] s1_d [RS_ENT];
    logic [DATA_W-1:0] s2_q [RS_ENT];
    logic [DATA_W-1:0] s2_d [RS_ENT];
    logic [TAG_W-1:0]  dst_q [RS_ENT];
    logic [TAG_W-1:0]  dst_d [RS_ENT];
    logic [PLD_W-1:0]  pld_q [RS_ENT];
    logic [PLD_W-1:0]  pld_d [RS_ENT];

    logic             first_vld, second_vld;
    logic [IDX_W-1:0] first_idx, second_idx;
    logic             dp1_ok, dp2_ok;
    logic [IDX_W-1:0] dp2_idx;
    logic [RS_ENT-1:0] ready;
    logic [IDX_W-1:0] iss_idx;
    logic             issue_fire;
    logic [CNT_W-1:0] busy_cnt;

    // A waiting source grabs a matching broadcast; wb1 has priority over wb2.
    function automatic logic [DATA_W:0] capture(input logic vld, input logic [DATA_W-1:0] opr);
        logic [DATA_W:0] r;
        r = {vld, opr};
        if (!vld) begin
            if (i_wb1_vld && (i_wb1_tag == opr[TAG_W-1:0]))
                r = {1'b1, i_wb1_data};
            else if (i_wb2_vld && (i_wb2_tag == opr[TAG_W-1:0]))
                r = {1'b1, i_wb2_data};
        end
        return r;
    endfunction

    // Find the two lowest free entries from the start-of-cycle busy vector.
    always_comb begin
        first_vld  = 1'b0;
        first_idx  = '0;
        second_vld = 1'b0;
        second_idx = '0;
        for (int i = 0; i < RS_ENT; i++) begin
            if (!busy_q[i]) begin
                if (!first_vld) begin
                    first_vld = 1'b1;
                    first_idx = IDX_W'(i);
                end else if (!second_vld) begin
                    second_vld = 1'b1;
                    second_idx = IDX_W'(i);
                end
            end
        end
    end

    assign dp1_ok  = i_dp1_we && first_vld;
    assign dp2_idx = i_dp1_we ? second_idx : first_idx;
    assign dp2_ok  = i_dp2_we && (i_dp1_we ? second_vld : first_vld);

    // Lowest-index ready entry is the issue candidate; occupancy count for free_cnt.
    always_comb begin
        ready    = busy_q & s1_vld_q & s2_vld_q;
        iss_idx  = '0;
        busy_cnt = '0;
        for (int i = RS_ENT - 1; i >= 0; i--) begin
            if (ready[i])
                iss_idx = IDX_W'(i);
            busy_cnt = busy_cnt + CNT_W'(busy_q[i]);
        end
    end

    assign o_issue_vld     = |ready;
    assign issue_fire      = o_issue_vld && i_issue_rdy;
    assign o_issue_src1    = s1_q[iss_idx];
    assign o_issue_src2    = s2_q[iss_idx];
    assign o_issue_dst_tag = dst_q[iss_idx];
    assign o_issue_pld     = pld_q[iss_idx];
    assign o_free_cnt      = CNT_W'(RS_ENT) - busy_cnt;

    // Next state: wakeup, issue release, dispatch writes with bypass; kill clears everything.
    always_comb begin
        busy_d   = busy_q;
        s1_vld_d = s1_vld_q;
        s2_vld_d = s2_vld_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        dst_d    = dst_q;
        pld_d    = pld_q;
        for (int i = 0; i < RS_ENT; i++) begin
            if (busy_q[i]) begin
                {s1_vld_d[i], s1_d[i]} = capture(s1_vld_q[i], s1_q[i]);
                {s2_vld_d[i], s2_d[i]} = capture(s2_vld_q[i], s2_q[i]);
            end
        end
        if (issue_fire)
            busy_d[iss_idx] = 1'b0;
        if (dp1_ok) begin
            busy_d[first_idx] = 1'b1;
            {s1_vld_d[first_idx], s1_d[first_idx]} = capture(i_dp1_src1_vld, i_dp1_src1);
            {s2_vld_d[first_idx], s2_d[first_idx]} = capture(i_dp1_src2_vld, i_dp1_src2);
            dst_d[first_idx] = i_dp1_dst_tag;
            pld_d[first_idx] = i_dp1_pld;
        end
        if (dp2_ok) begin
            busy_d[dp2_idx] = 1'b1;
            {s1_vld_d[dp2_idx], s1_d[dp2_idx]} = capture(i_dp2_src1_vld, i_dp2_src1);
            {s2_vld_d[dp2_idx], s2_d[dp2_idx]} = capture(i_dp2_src2_vld, i_dp2_src2);
            dst_d[dp2_idx] = i_dp2_dst_tag;
            pld_d[dp2_idx] = i_dp2_pld;
        end
        if (i_kill)
            busy_d = '0;
    end

    // Occupancy is the only reset state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    // Operand and payload storage; meaningless while the entry is not busy.
    always_ff @(posedge i_clk) begin
        s1_vld_q <= s1_vld_d;
        s2_vld_q <= s2_vld_d;
        s1_q     <= s1_d;
        s2_q     <= s2_d;
        dst_q    <= dst_d;
        pld_q    <= pld_d;
    end

`ifndef SYNTHESIS
    // Flag dispatch beyond the advertised free count; the write itself is dropped.
    always @(posedge i_clk) begin
        if (i_rst_n && !i_kill && ((i_dp1_we && !dp1_ok) || (i_dp2_we && !dp2_ok)))
            $error("rs_alu: dispatch with no free entry dropped");
    end
`endif

endmodule

// File: tb/tb_rs_alu.sv
// tb/tb_rs_alu.sv - scoreboard bench for rs_alu
module tb_rs_alu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        kill;
    logic        dp1_we, dp1_s1v, dp1_s2v, dp2_we, dp2_s1v, dp2_s2v;
    logic [31:0] dp1_s1, dp1_s2, dp2_s1, dp2_s2;
    logic [5:0]  dp1_tag, dp2_tag;
    logic [15:0] dp1_pld, dp2_pld;
    logic        wb1_vld, wb2_vld;
    logic [5:0]  wb1_tag, wb2_tag;
    logic [31:0] wb1_data, wb2_data;
    logic [3:0]  free_cnt;
    logic        issue_vld, issue_rdy;
    logic [31:0] iss_s1, iss_s2;
    logic [5:0]  iss_tag;
    logic [15:0] iss_pld;

    typedef struct packed {
        logic [31:0] s1;
        logic [31:0] s2;
        logic [5:0]  tag;
        logic [15:0] pld;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    rs_alu dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_kill(kill),
        .i_dp1_we(dp1_we), .i_dp1_src1_vld(dp1_s1v), .i_dp1_src1(dp1_s1),
        .i_dp1_src2_vld(dp1_s2v), .i_dp1_src2(dp1_s2), .i_dp1_dst_tag(dp1_tag), .i_dp1_pld(dp1_pld),
        .i_dp2_we(dp2_we), .i_dp2_src1_vld(dp2_s1v), .i_dp2_src1(dp2_s1),
        .i_dp2_src2_vld(dp2_s2v), .i_dp2_src2(dp2_s2), .i_dp2_dst_tag(dp2_tag), .i_dp2_pld(dp2_pld),
        .i_wb1_vld(wb1_vld), .i_wb1_tag(wb1_tag), .i_wb1_data(wb1_data),
        .i_wb2_vld(wb2_vld), .i_wb2_tag(wb2_tag), .i_wb2_data(wb2_data),
        .o_free_cnt(free_cnt), .o_issue_vld(issue_vld), .i_issue_rdy(issue_rdy),
        .o_issue_src1(iss_s1), .o_issue_src2(iss_s2), .o_issue_dst_tag(iss_tag), .o_issue_pld(iss_pld)
    );

    always #5 clk = ~clk;

    // Monitor: every accepted issue is matched against the oldest expected response.
    always @(negedge clk) begin
        if (rst_n && issue_vld && issue_rdy && !kill) begin
            exp_t act, exp;
            act = '{s1: iss_s1, s2: iss_s2, tag: iss_tag, pld: iss_pld};
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL issue_unexpected: got tag=%0d s1=%h s2=%h, required no issue", iss_tag, iss_s1, iss_s2);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    n_err++;
                    $display("FAIL issue_tag%0d: got s1=%h s2=%h tag=%0d pld=%h, required s1=%h s2=%h tag=%0d pld=%h",
                             exp.tag, act.s1, act.s2, act.tag, act.pld, exp.s1, exp.s2, exp.tag, exp.pld);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        kill = 0; dp1_we = 0; dp2_we = 0; wb1_vld = 0; wb2_vld = 0;
        dp1_s1v = 0; dp1_s2v = 0; dp2_s1v = 0; dp2_s2v = 0;
        dp1_s1 = 0; dp1_s2 = 0; dp2_s1 = 0; dp2_s2 = 0;
        dp1_tag = 0; dp2_tag = 0; dp1_pld = 0; dp2_pld = 0;
        wb1_tag = 0; wb2_tag = 0; wb1_data = 0; wb2_data = 0;
    endtask

    task automatic dp(input int k, input logic v1, input logic [31:0] s1,
                      input logic v2, input logic [31:0] s2, input logic [5:0] tag);
        if (k == 1) begin
            dp1_we = 1; dp1_s1v = v1; dp1_s1 = s1; dp1_s2v = v2; dp1_s2 = s2;
            dp1_tag = tag; dp1_pld = 16'hA000 + 16'(tag);
        end else begin
            dp2_we = 1; dp2_s1v = v2 ? v1 : v1; dp2_s1 = s1; dp2_s2v = v2; dp2_s2 = s2;
            dp2_tag = tag; dp2_pld = 16'hA000 + 16'(tag);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] s1, input logic [31:0] s2, input logic [5:0] tag);
        return '{s1: s1, s2: s2, tag: tag, pld: 16'hA000 + 16'(tag)};
    endfunction

    initial begin
        idle();
        issue_rdy = 0;
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        tick();
        chk("reset_free_cnt", 32'(free_cnt), 8);
        chk("reset_issue_vld", 32'(issue_vld), 0);

        // 1: single ready dispatch
        dp(1, 1, 32'd5, 1, 32'd7, 6'd3);
        exp_q.push_back(mk(32'd5, 32'd7, 6'd3));
        tick(); idle();
        chk("t1_issue_vld", 32'(issue_vld), 1);
        chk("t1_free_cnt", 32'(free_cnt), 7);
        issue_rdy = 1;
        tick(); issue_rdy = 0;
        chk("t1_free_after", 32'(free_cnt), 8);

        // 2: wakeup from wb1, issue only the cycle after the broadcast
        issue_rdy = 1;
        dp(1, 0, 32'h0A, 1, 32'h2, 6'd11);
        exp_q.push_back(mk(32'h1234, 32'h2, 6'd11));
        tick(); idle();
        chk("t2_wait1", 32'(issue_vld), 0);
        tick();
        chk("t2_wait2", 32'(issue_vld), 0);
        wb1_vld = 1; wb1_tag = 6'd10; wb1_data = 32'h1234;
        tick(); idle();
        chk("t2_woken", 32'(issue_vld), 1);
        tick();
        chk("t2_free_after", 32'(free_cnt), 8);
        issue_rdy = 0;

        // 3: dispatch bypass on both ports from wb2
        dp(1, 0, 32'd4, 1, 32'd1, 6'd20);
        dp(2, 1, 32'h55, 0, 32'd4, 6'd21);
        wb2_vld = 1; wb2_tag = 6'd4; wb2_data = 32'h99;
        exp_q.push_back(mk(32'h99, 32'd1, 6'd20));
        exp_q.push_back(mk(32'h55, 32'h99, 6'd21));
        tick(); idle();
        chk("t3_free_cnt", 32'(free_cnt), 6);
        chk("t3_issue_vld", 32'(issue_vld), 1);
        issue_rdy = 1;
        tick();
        chk("t3_second_vld", 32'(issue_vld), 1);
        tick(); issue_rdy = 0;
        chk("t3_free_after", 32'(free_cnt), 8);

        // 4: fill all entries, hold, drain in index order
        for (int c = 0; c < 4; c++) begin
            dp(1, 1, 32'(c * 32), 1, 32'(c * 32 + 1), 6'(30 + 2 * c));
            dp(2, 1, 32'(c * 32 + 16), 1, 32'(c * 32 + 17), 6'(31 + 2 * c));
            exp_q.push_back(mk(32'(c * 32), 32'(c * 32 + 1), 6'(30 + 2 * c)));
            exp_q.push_back(mk(32'(c * 32 + 16), 32'(c * 32 + 17), 6'(31 + 2 * c)));
            tick(); idle();
        end
        chk("t4_full", 32'(free_cnt), 0);
        chk("t4_hold_tag", 32'(iss_tag), 30);
        tick();
        chk("t4_hold_tag2", 32'(iss_tag), 30);
        issue_rdy = 1;
        for (int i = 0; i < 8; i++) tick();
        issue_rdy = 0;
        chk("t4_drained", 32'(free_cnt), 8);
        chk("t4_vld_off", 32'(issue_vld), 0);

        // 5: kill overrides dispatch and issue
        dp(1, 1, 32'd1, 1, 32'd1, 6'd50);
        dp(2, 1, 32'd2, 1, 32'd2, 6'd51);
        tick(); idle();
        dp(1, 1, 32'd3, 1, 32'd3, 6'd52);
        dp(2, 1, 32'd4, 1, 32'd4, 6'd53);
        tick(); idle();
        dp(1, 0, 32'd9, 1, 32'd5, 6'd54);
        tick(); idle();
        chk("t5_five_busy", 32'(free_cnt), 3);
        kill = 1; issue_rdy = 1;
        dp(1, 1, 32'd6, 1, 32'd6, 6'd55);
        tick(); idle(); issue_rdy = 0;
        chk("t5_kill_free", 32'(free_cnt), 8);
        chk("t5_kill_vld", 32'(issue_vld), 0);

        // 6: both buses match, wb1 wins
        dp(1, 0, 32'd6, 1, 32'h3, 6'd40);
        exp_q.push_back(mk(32'h11, 32'h3, 6'd40));
        tick(); idle();
        chk("t6_wait", 32'(issue_vld), 0);
        wb1_vld = 1; wb1_tag = 6'd6; wb1_data = 32'h11;
        wb2_vld = 1; wb2_tag = 6'd6; wb2_data = 32'h22;
        issue_rdy = 1;
        tick(); idle();
        chk("t6_woken", 32'(issue_vld), 1);
        tick(); issue_rdy = 0;
        chk("t6_free_after", 32'(free_cnt), 8);

        tick();
        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
